// File: rtl/cache_mesi_directory_if.sv
// Request / snoop / response bundle between the caching agents and the MESI directory.
// The master modport is the agent side; the slave modport is the directory side.
interface cache_mesi_directory_if #(
    parameter int NUM_AGENTS = 4,
    parameter int NUM_LINES  = 64
);
    localparam int AW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [AW-1:0]         req_agent;
    logic [IW-1:0]         req_index;
    logic [1:0]            req_op;
    logic                  snoop_valid;
    logic [NUM_AGENTS-1:0] snoop_mask;
    logic                  snoop_invalidate;
    logic                  snoop_ack;
    logic                  snoop_dirty;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [AW-1:0]         resp_agent;
    logic [1:0]            resp_state;
    logic                  resp_data;

    modport master (
        output req_valid, req_agent, req_index, req_op, snoop_ack, snoop_dirty, resp_ready,
        input  req_ready, snoop_valid, snoop_mask, snoop_invalidate,
               resp_valid, resp_agent, resp_state, resp_data
    );

    modport slave (
        input  req_valid, req_agent, req_index, req_op, snoop_ack, snoop_dirty, resp_ready,
        output req_ready, snoop_valid, snoop_mask, snoop_invalidate,
               resp_valid, resp_agent, resp_state, resp_data
    );
endinterface

// File: rtl/cache_mesi_directory.sv
// MESI coherence directory: serialises agent requests, snoops other holders,
// and grants a MESI state per line. One transaction in flight at a time.
package cache_mesi_pkg;
    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } cache_mesi_state_t;

    typedef enum logic [1:0] {
        OP_SHARED         = 2'd0,
        OP_EXCLUSIVE      = 2'd1,
        OP_EXCLUSIVE_DATA = 2'd2,
        OP_EVICTION       = 2'd3
    } cache_mesi_operation_t;
endpackage

module cache_mesi_directory
    import cache_mesi_pkg::*;
#(
    parameter int NUM_AGENTS              = 4,
    parameter int NUM_LINES               = 64,
    parameter bit GRANT_EXCLUSIVE_ON_MISS = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    cache_mesi_directory_if.slave bus
);
    localparam int AW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_SNOOP   = 2'd2,
        ST_RESPOND = 2'd3
    } fsm_t;

    function automatic logic [NUM_AGENTS-1:0] agent_bit(input logic [AW-1:0] id);
        logic [NUM_AGENTS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Directory storage: E also stands for silently upgraded M.
    cache_mesi_state_t     dir_state_q   [NUM_LINES];
    logic [NUM_AGENTS-1:0] dir_sharers_q [NUM_LINES];

    fsm_t                  state_q, state_d;
    logic [AW-1:0]         agent_q, agent_d;
    logic [IW-1:0]         index_q, index_d;
    cache_mesi_operation_t op_q, op_d;
    cache_mesi_state_t     pend_state_q, pend_state_d;
    logic [NUM_AGENTS-1:0] pend_sharers_q, pend_sharers_d;
    logic [NUM_AGENTS-1:0] snoop_mask_q, snoop_mask_d;
    logic                  snoop_inv_q, snoop_inv_d;
    logic [AW-1:0]         resp_agent_q, resp_agent_d;
    cache_mesi_state_t     resp_state_q, resp_state_d;
    logic                  resp_data_q, resp_data_d;
    logic                  req_ready_q, req_ready_d;
    logic                  snoop_valid_q, snoop_valid_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  dirty_q, dirty_d;

    cache_mesi_state_t     ent_state_s;
    logic [NUM_AGENTS-1:0] ent_sh_s;
    logic [NUM_AGENTS-1:0] req_bit_s;
    logic [NUM_AGENTS-1:0] others_s;
    logic                  is_sharer_s;
    logic                  lk_snoop_s;
    logic [NUM_AGENTS-1:0] lk_mask_s;
    logic                  lk_inv_s;
    cache_mesi_state_t     lk_state_s;
    logic [NUM_AGENTS-1:0] lk_sh_s;
    cache_mesi_state_t     lk_grant_s;
    logic                  lk_data_s;
    logic                  dir_wr_s;
    cache_mesi_state_t     wr_state_s;
    logic [NUM_AGENTS-1:0] wr_sh_s;

    // Coherence decision for the latched request against the current entry.
    always_comb begin
        ent_state_s = dir_state_q[index_q];
        ent_sh_s    = dir_sharers_q[index_q];
        req_bit_s   = agent_bit(agent_q);
        others_s    = ent_sh_s & ~req_bit_s;
        is_sharer_s = |(ent_sh_s & req_bit_s);
        lk_snoop_s  = 1'b0;
        lk_mask_s   = '0;
        lk_inv_s    = 1'b0;
        lk_state_s  = ent_state_s;
        lk_sh_s     = ent_sh_s;
        lk_grant_s  = MESI_I;
        lk_data_s   = 1'b0;
        case (op_q)
            OP_SHARED: begin
                case (ent_state_s)
                    MESI_S: begin
                        lk_grant_s = MESI_S;
                        lk_sh_s    = ent_sh_s | req_bit_s;
                        lk_data_s  = ~is_sharer_s;
                    end
                    MESI_E: begin
                        if (is_sharer_s) begin
                            lk_grant_s = MESI_E;
                            lk_data_s  = 1'b0;
                        end else begin
                            lk_snoop_s = 1'b1;
                            lk_mask_s  = others_s;
                            lk_inv_s   = 1'b0;
                            lk_state_s = MESI_S;
                            lk_sh_s    = ent_sh_s | req_bit_s;
                            lk_grant_s = MESI_S;
                            lk_data_s  = 1'b1;
                        end
                    end
                    default: begin
                        lk_grant_s = GRANT_EXCLUSIVE_ON_MISS ? MESI_E : MESI_S;
                        lk_state_s = GRANT_EXCLUSIVE_ON_MISS ? MESI_E : MESI_S;
                        lk_sh_s    = req_bit_s;
                        lk_data_s  = 1'b1;
                    end
                endcase
            end
            OP_EXCLUSIVE, OP_EXCLUSIVE_DATA: begin
                lk_snoop_s = |others_s;
                lk_mask_s  = others_s;
                lk_inv_s   = 1'b1;
                lk_state_s = MESI_E;
                lk_sh_s    = req_bit_s;
                lk_grant_s = MESI_E;
                lk_data_s  = (op_q == OP_EXCLUSIVE_DATA) | ~is_sharer_s;
            end
            OP_EVICTION: begin
                lk_sh_s    = ent_sh_s & ~req_bit_s;
                lk_state_s = (|lk_sh_s) ? ent_state_s : MESI_I;
                lk_grant_s = MESI_I;
                lk_data_s  = 1'b0;
            end
            default: begin
                lk_grant_s = MESI_I;
            end
        endcase
    end

    // Transaction FSM next state, latched fields and registered-output next values.
    always_comb begin
        state_d        = state_q;
        agent_d        = agent_q;
        index_d        = index_q;
        op_d           = op_q;
        pend_state_d   = pend_state_q;
        pend_sharers_d = pend_sharers_q;
        snoop_mask_d   = snoop_mask_q;
        snoop_inv_d    = snoop_inv_q;
        resp_agent_d   = resp_agent_q;
        resp_state_d   = resp_state_q;
        resp_data_d    = resp_data_q;
        dirty_d        = dirty_q;
        dir_wr_s       = 1'b0;
        wr_state_s     = pend_state_q;
        wr_sh_s        = pend_sharers_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    agent_d = bus.req_agent;
                    index_d = bus.req_index;
                    op_d    = cache_mesi_operation_t'(bus.req_op);
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                pend_state_d   = lk_state_s;
                pend_sharers_d = lk_sh_s;
                resp_agent_d   = agent_q;
                resp_state_d   = lk_grant_s;
                resp_data_d    = lk_data_s;
                if (lk_snoop_s) begin
                    state_d      = ST_SNOOP;
                    snoop_mask_d = lk_mask_s;
                    snoop_inv_d  = lk_inv_s;
                end else begin
                    state_d    = ST_RESPOND;
                    dir_wr_s   = 1'b1;
                    wr_state_s = lk_state_s;
                    wr_sh_s    = lk_sh_s;
                end
            end
            ST_SNOOP: begin
                if (bus.snoop_ack) begin
                    state_d      = ST_RESPOND;
                    dir_wr_s     = 1'b1;
                    dirty_d      = bus.snoop_dirty;
                    snoop_mask_d = '0;
                    snoop_inv_d  = 1'b0;
                end else begin
                    state_d = ST_SNOOP;
                end
            end
            ST_RESPOND: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d   = (state_d == ST_IDLE);
        snoop_valid_d = (state_d == ST_SNOOP);
        resp_valid_d  = (state_d == ST_RESPOND);
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            agent_q        <= '0;
            index_q        <= '0;
            op_q           <= OP_SHARED;
            pend_state_q   <= MESI_I;
            pend_sharers_q <= '0;
            snoop_mask_q   <= '0;
            snoop_inv_q    <= 1'b0;
            resp_agent_q   <= '0;
            resp_state_q   <= MESI_I;
            resp_data_q    <= 1'b0;
            req_ready_q    <= 1'b1;
            snoop_valid_q  <= 1'b0;
            resp_valid_q   <= 1'b0;
            dirty_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            agent_q        <= agent_d;
            index_q        <= index_d;
            op_q           <= op_d;
            pend_state_q   <= pend_state_d;
            pend_sharers_q <= pend_sharers_d;
            snoop_mask_q   <= snoop_mask_d;
            snoop_inv_q    <= snoop_inv_d;
            resp_agent_q   <= resp_agent_d;
            resp_state_q   <= resp_state_d;
            resp_data_q    <= resp_data_d;
            req_ready_q    <= req_ready_d;
            snoop_valid_q  <= snoop_valid_d;
            resp_valid_q   <= resp_valid_d;
            dirty_q        <= dirty_d;
        end
    end

    // Directory entries are committed only on entry to RESPOND, so reset mid-snoop leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                dir_state_q[i]   <= MESI_I;
                dir_sharers_q[i] <= '0;
            end
        end else if (dir_wr_s) begin
            dir_state_q[index_q]   <= wr_state_s;
            dir_sharers_q[index_q] <= wr_sh_s;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.snoop_valid      = snoop_valid_q;
    assign bus.snoop_mask       = snoop_mask_q;
    assign bus.snoop_invalidate = snoop_inv_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_agent       = resp_agent_q;
    assign bus.resp_state       = resp_state_q;
    assign bus.resp_data        = resp_data_q;
endmodule

// File: tb/tb_cache_mesi_directory.sv
// Bench for cache_mesi_directory: directed vector table, multi-cycle corner sequences,
// and random traffic against a holder-set reference model.
module tb_cache_mesi_directory;
    import cache_mesi_pkg::*;

    localparam int NA = 4;
    localparam int NL = 64;

    typedef struct {
        int         a;
        int         idx;
        int         op;
        int         ackd;
        int         rrd;
        bit         spur;
        bit         sn;
        logic [3:0] mask;
        bit         inv;
        int         gs;
        bit         gd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bit hold [NL][NA];
    bit excl [NL];

    always #5 clk = ~clk;

    cache_mesi_directory_if #(.NUM_AGENTS(NA), .NUM_LINES(NL)) bus ();
    cache_mesi_directory_if #(.NUM_AGENTS(NA), .NUM_LINES(NL)) bus_s ();

    cache_mesi_directory #(.NUM_AGENTS(NA), .NUM_LINES(NL), .GRANT_EXCLUSIVE_ON_MISS(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    cache_mesi_directory #(.NUM_AGENTS(NA), .NUM_LINES(NL), .GRANT_EXCLUSIVE_ON_MISS(1'b0))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            excl[l] = 1'b0;
            for (int k = 0; k < NA; k++) hold[l][k] = 1'b0;
        end
    endtask

    // Reference: a line is a set of holders plus an "exclusive owner" flag.
    task automatic predict(input int a, input int idx, input int op, output bit sn,
                           output logic [3:0] mask, output bit inv, output int gs, output bit gd);
        int n;
        int left;
        bit is_h;
        n = 0;
        mask = 4'b0000;
        for (int k = 0; k < NA; k++) begin
            if (hold[idx][k]) n++;
            if (hold[idx][k] && k != a) mask[k] = 1'b1;
        end
        is_h = hold[idx][a];
        sn = 1'b0; inv = 1'b0; gs = 0; gd = 1'b0;
        if (op == 0) begin
            if (n == 0) begin
                gs = 2; gd = 1'b1; hold[idx][a] = 1'b1; excl[idx] = 1'b1;
            end else if (excl[idx] && is_h) begin
                gs = 2; gd = 1'b0;
            end else if (excl[idx]) begin
                sn = 1'b1; gs = 1; gd = 1'b1; hold[idx][a] = 1'b1; excl[idx] = 1'b0;
            end else begin
                gs = 1; gd = !is_h; hold[idx][a] = 1'b1;
            end
        end else if (op == 1 || op == 2) begin
            sn = (mask != 4'b0000); inv = 1'b1; gs = 2;
            gd = (op == 2) || !is_h;
            for (int k = 0; k < NA; k++) hold[idx][k] = (k == a);
            excl[idx] = 1'b1;
        end else begin
            hold[idx][a] = 1'b0;
            left = 0;
            for (int k = 0; k < NA; k++) if (hold[idx][k]) left++;
            if (left == 0) excl[idx] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_agent = 2'(v.a);
        bus.req_index = 6'(v.idx);
        bus.req_op    = 2'(v.op);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.snoop_ack = v.spur;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.snoop_ack = 1'b0;
        chk("snoop_valid", 32'(bus.snoop_valid), 32'(v.sn));
        if (v.sn) begin
            chk("snoop_mask", 32'(bus.snoop_mask), 32'(v.mask));
            chk("snoop_inv", 32'(bus.snoop_invalidate), 32'(v.inv));
            chk("resp_early", 32'(bus.resp_valid), 32'd0);
            for (int i = 0; i < v.ackd; i++) begin
                @(negedge clk);
                chk("snoop_hold", 32'(bus.snoop_valid), 32'd1);
                chk("snoop_mask_hold", 32'(bus.snoop_mask), 32'(v.mask));
            end
            bus.snoop_ack   = 1'b1;
            bus.snoop_dirty = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.snoop_ack   = 1'b0;
            bus.snoop_dirty = 1'b0;
            chk("snoop_release", 32'(bus.snoop_valid), 32'd0);
        end
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_agent", 32'(bus.resp_agent), 32'(v.a));
        chk("resp_state", 32'(bus.resp_state), 32'(v.gs));
        chk("resp_data", 32'(bus.resp_data), 32'(v.gd));
        for (int i = 0; i < v.rrd; i++) begin
            @(negedge clk);
            chk("resp_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("resp_hold_state", 32'(bus.resp_state), 32'(v.gs));
            chk("resp_hold_data", 32'(bus.resp_data), 32'(v.gd));
            chk("req_ready_hold", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        vec_t tbl [$];
        vec_t v;
        int   k;
        int   acc;
        int   rsp;

        bus.req_valid = 1'b0; bus.req_agent = '0; bus.req_index = '0; bus.req_op = '0;
        bus.snoop_ack = 1'b0; bus.snoop_dirty = 1'b0; bus.resp_ready = 1'b0;
        bus_s.req_valid = 1'b0; bus_s.req_agent = '0; bus_s.req_index = '0; bus_s.req_op = '0;
        bus_s.snoop_ack = 1'b0; bus_s.snoop_dirty = 1'b0; bus_s.resp_ready = 1'b0;

        //            a idx op ackd rrd spur sn mask  inv gs gd
        tbl.push_back('{0, 5, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1});
        tbl.push_back('{2, 5, 0, 3, 0, 1'b0, 1'b1, 4'h1, 1'b0, 1, 1'b1});
        tbl.push_back('{0, 9, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1});
        tbl.push_back('{1, 9, 0, 0, 0, 1'b1, 1'b1, 4'h1, 1'b0, 1, 1'b1});
        tbl.push_back('{2, 9, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1, 1'b1});
        tbl.push_back('{1, 9, 1, 1, 0, 1'b0, 1'b1, 4'h5, 1'b1, 2, 1'b0});
        tbl.push_back('{1, 9, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b0});
        tbl.push_back('{0, 3, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1});
        tbl.push_back('{1, 3, 0, 0, 0, 1'b0, 1'b1, 4'h1, 1'b0, 1, 1'b1});
        tbl.push_back('{0, 3, 3, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0});
        tbl.push_back('{1, 3, 3, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0});
        tbl.push_back('{3, 3, 3, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0});
        tbl.push_back('{2, 3, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1});
        tbl.push_back('{3, 5, 2, 2, 0, 1'b0, 1'b1, 4'h5, 1'b1, 2, 1'b1});
        tbl.push_back('{3, 5, 1, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b0});
        tbl.push_back('{0, 7, 1, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1});
        tbl.push_back('{2, 5, 0, 0, 5, 1'b0, 1'b1, 4'h8, 1'b0, 1, 1'b1});
        tbl.push_back('{2, 5, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1, 1'b0});

        do_reset();
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_snoop_valid", 32'(bus.snoop_valid), 32'd0);
        chk("rst_snoop_mask", 32'(bus.snoop_mask), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_fields", {29'd0, bus.resp_agent, bus.resp_data}, 32'd0);
        chk("rst_resp_state", 32'(bus.resp_state), 32'd0);

        // Miss without exclusive-on-miss grants S after two cycles.
        bus_s.req_valid = 1'b1; bus_s.req_agent = 2'd0; bus_s.req_index = 6'd5; bus_s.req_op = 2'd0;
        @(negedge clk);
        bus_s.req_valid = 1'b0;
        k = 1;
        while (!bus_s.resp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("gx0_latency", 32'(k), 32'd2);
        chk("gx0_state", 32'(bus_s.resp_state), 32'(MESI_S));
        chk("gx0_data", 32'(bus_s.resp_data), 32'd1);
        bus_s.resp_ready = 1'b1;
        @(negedge clk);
        bus_s.resp_ready = 1'b0;

        for (int i = 0; i < tbl.size(); i++) do_txn(tbl[i]);

        // Reset while a snoop is outstanding: entry for idx5 must not be touched.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_agent = 2'd1; bus.req_index = 6'd5; bus.req_op = 2'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_snoop", 32'(bus.snoop_valid), 32'd1);
        chk("pre_rst_mask", 32'(bus.snoop_mask), 32'hC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_snoop_valid", 32'(bus.snoop_valid), 32'd0);
        chk("mid_rst_snoop_mask", 32'(bus.snoop_mask), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        v = '{1, 5, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1};
        do_txn(v);
        v = '{0, 9, 0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1};
        do_txn(v);

        // Back-to-back with req_valid held high: one accept per three-cycle transaction.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_agent = 2'd0; bus.req_index = 6'd20; bus.req_op = 2'd0;
        bus.resp_ready = 1'b1;
        acc = 0;
        rsp = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.req_valid && bus.req_ready) acc++;
            if (bus.resp_valid && bus.resp_ready) rsp++;
            chk("b2b_ready_vs_resp", 32'(bus.req_ready & bus.resp_valid), 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd10);
        chk("b2b_resps", 32'(rsp), 32'd10);
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Random traffic on a few lines so requests collide.
        do_reset();
        model_reset();
        for (int t = 0; t < 250; t++) begin
            bit         p_sn;
            logic [3:0] p_mask;
            bit         p_inv;
            int         p_gs;
            bit         p_gd;
            v.a    = $urandom_range(0, NA - 1);
            v.idx  = $urandom_range(0, 7);
            v.op   = $urandom_range(0, 3);
            v.ackd = $urandom_range(0, 3);
            v.rrd  = $urandom_range(0, 2);
            v.spur = 1'($urandom_range(0, 1));
            predict(v.a, v.idx, v.op, p_sn, p_mask, p_inv, p_gs, p_gd);
            v.sn   = p_sn;
            v.mask = p_mask;
            v.inv  = p_inv;
            v.gs   = p_gs;
            v.gd   = p_gd;
            do_txn(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
